// File: rtl/minimax_lsu.sv
// minimax_lsu: byte/half/word load/store unit with in-order multi-load tracking.
// Define MINIMAX_LSU_MISALIGN_TRAP_EN to add mis_valid/mis_addr misalign reporting.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid/ready/we/size/signed/addr/wdata/tag   access from execute stage
//   bus_rreq/wreq/addr/wdata/wmask, bus_gnt         registered bus request
//   bus_rvalid/rdata                                in-order read return
//   rsp_valid/tag/data           extended load result, one-cycle pulse
//   pending                      loads granted but not yet returned
//   unexp_rvalid                 read data arrived with nothing tracked
//   mis_valid/mis_addr           (trap build only) misaligned access report
module minimax_lsu #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [TAG_W-1:0]          req_tag,
  output logic                      bus_rreq,
  output logic                      bus_wreq,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [31:0]               bus_wdata,
  output logic [3:0]                bus_wmask,
  input  logic                      bus_gnt,
  input  logic                      bus_rvalid,
  input  logic [31:0]               bus_rdata,
  output logic                      rsp_valid,
  output logic [TAG_W-1:0]          rsp_tag,
  output logic [31:0]               rsp_data,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      unexp_rvalid
`ifdef MINIMAX_LSU_MISALIGN_TRAP_EN
  ,
  output logic                      mis_valid,
  output logic [ADDR_W-1:0]         mis_addr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0]       size;
    logic             sgn;
    logic [1:0]       sh;
  } ld_t;

  ld_t             issue_ld;
  ld_t             fifo [DEPTH];
  ld_t             head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [1:0]      off;
  logic [1:0]      sh;
  logic            is_half;
  logic            is_word;
  logic            mis;
  logic            issue_full;
  logic            grant;
  logic            push;
  logic            pop;
  logic            accept;
  logic [3:0]      wmask;
  logic [31:0]     wdata;
  logic [31:0]     shifted;
  logic [31:0]     ext;

  assign off     = req_addr[1:0];
  assign is_word = req_size[1];
  assign is_half = (req_size == 2'd1);

`ifdef MINIMAX_LSU_MISALIGN_TRAP_EN
  assign mis = (is_half & off[0]) | (is_word & (off != 2'd0));
`else
  assign mis = 1'b0;
`endif

  assign issue_full = bus_rreq | bus_wreq;
  assign grant      = issue_full & bus_gnt;
  assign push       = grant & bus_rreq;
  assign pop        = bus_rvalid & (count != '0);

  // Loads held in the tracker or waiting in the issue register, minus the
  // one retiring this cycle, must leave room for another.
  assign occ = {1'b0, count} + (CW+1)'(bus_rreq) - (CW+1)'(pop);

  assign req_ready = reset_n & (~issue_full | bus_gnt)
                   & (req_we | (occ < (CW+1)'(DEPTH)));
  assign accept    = req_valid & req_ready;

  always_comb begin
    sh    = 2'd0;
    wmask = 4'hF;
    wdata = req_wdata;
    if (is_word) begin
      sh    = 2'd0;
    end else if (is_half) begin
      sh    = {off[1], 1'b0};
      wmask = 4'b0011 << sh;
      wdata = {2{req_wdata[15:0]}};
    end else begin
      sh    = off;
      wmask = 4'b0001 << sh;
      wdata = {4{req_wdata[7:0]}};
    end
  end

  assign head    = fifo[rd_ptr];
  assign shifted = bus_rdata >> {head.sh, 3'b000};

  always_comb begin
    ext = shifted;
    unique case (head.size)
      2'd0:    ext = {{24{head.sgn & shifted[7]}}, shifted[7:0]};
      2'd1:    ext = {{16{head.sgn & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= issue_ld;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_rreq     <= 1'b0;
      bus_wreq     <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_wmask    <= '0;
      issue_ld     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rsp_valid    <= 1'b0;
      rsp_tag      <= '0;
      rsp_data     <= '0;
      unexp_rvalid <= 1'b0;
    end else begin
      if (accept && !mis) begin
        bus_rreq  <= ~req_we;
        bus_wreq  <= req_we;
        bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        bus_wdata <= req_we ? wdata : 32'd0;
        bus_wmask <= req_we ? wmask : 4'd0;
        issue_ld  <= '{tag: req_tag, size: req_size,
                       sgn: req_signed, sh: sh};
      end else if (grant) begin
        bus_rreq  <= 1'b0;
        bus_wreq  <= 1'b0;
        bus_addr  <= '0;
        bus_wdata <= '0;
        bus_wmask <= '0;
        issue_ld  <= '0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count + CW'(push) - CW'(pop);
      rsp_valid    <= pop;
      rsp_tag      <= pop ? head.tag : '0;
      rsp_data     <= pop ? ext : 32'd0;
      unexp_rvalid <= bus_rvalid & (count == '0);
    end
  end

`ifdef MINIMAX_LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mis_valid <= 1'b0;
      mis_addr  <= '0;
    end else begin
      mis_valid <= accept & mis;
      mis_addr  <= (accept & mis) ? req_addr : '0;
    end
  end
`endif

  assign pending = count;

endmodule

// File: tb/tb_minimax_lsu.sv
// tb_minimax_lsu: scoreboard bench for minimax_lsu.
// Expected load results are queued at issue and compared on rsp_valid.
module tb_minimax_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [5:0]  req_tag = '0;
  logic        bus_rreq;
  logic        bus_wreq;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        rsp_valid;
  logic [5:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic [2:0]  pending;
  logic        unexp_rvalid;
`ifdef MINIMAX_LSU_MISALIGN_TRAP_EN
  logic        mis_valid;
  logic [31:0] mis_addr;
`endif

  minimax_lsu #(.ADDR_W(32), .DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .bus_rreq(bus_rreq), .bus_wreq(bus_wreq),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wmask(bus_wmask), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .rsp_data(rsp_data), .pending(pending),
    .unexp_rvalid(unexp_rvalid)
`ifdef MINIMAX_LSU_MISALIGN_TRAP_EN
    ,
    .mis_valid(mis_valid), .mis_addr(mis_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q [$];
  logic [31:0] rd_q [$];
  rsp_t        cur;
  int          errs = 0;
  int          checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] size,
                                        input logic sgn,
                                        input logic [1:0] off,
                                        input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> (8 * int'(off)));
    h = 16'(rd >> (off[1] ? 16 : 0));
    case (size)
      2'd0:    return sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'd1:    return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: return rd;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [5:0] tag,
                       input logic [31:0] rd);
    int n;
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd; req_tag = tag;
    req_valid = 1'b1;
    n = 0;
    #1;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      check("issue_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (!we) begin
      rd_q.push_back(rd);
      exp_q.push_back('{tag, model(size, sgn, addr[1:0], rd)});
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic ret();
    if (rd_q.size() == 0) begin
      check("ret_empty", 32'd0, 32'd1);
      return;
    end
    bus_rvalid = 1'b1;
    bus_rdata = rd_q.pop_front();
    step();
    bus_rvalid = 1'b0;
    bus_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("rsp_tag", 32'(rsp_tag), 32'(cur.tag));
        check("rsp_data", rsp_data, cur.data);
      end
    end
  end

  initial begin
    int held;
    req_valid = 1'b1;
    req_we = 1'b1;
    repeat (2) step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_wreq", 32'(bus_wreq), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    reset_n = 1'b1;
    step();

    // T1: word store with delayed grant
    bus_gnt = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 6'd0, 32'd0);
    check("t1_wreq", 32'(bus_wreq), 32'd1);
    check("t1_addr", bus_addr, 32'h104);
    check("t1_wmask", 32'(bus_wmask), 32'hF);
    check("t1_wdata", bus_wdata, 32'hDEADBEEF);
    held = 0;
    for (int i = 0; i < 10 && bus_wreq; i++) begin
      held++;
      if (held == 3) bus_gnt = 1'b1;
      step();
    end
    bus_gnt = 1'b0;
    check("t1_held", 32'(held), 32'd3);
    check("t1_idle_wdata", bus_wdata, 32'd0);

    // T2: byte and half stores
    bus_gnt = 1'b1;
    issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 6'd0, 32'd0);
    check("t2_sb_wmask", 32'(bus_wmask), 32'h8);
    check("t2_sb_wdata", bus_wdata, 32'hA5A5A5A5);
    check("t2_sb_addr", bus_addr, 32'h100);
    issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 6'd0, 32'd0);
    check("t2_sh_wmask", 32'(bus_wmask), 32'hC);
    check("t2_sh_wdata", bus_wdata, 32'h12341234);
    step();
    check("t2_idle", 32'(bus_wreq), 32'd0);

    // T3: signed byte and unsigned half loads
    issue(1'b0, 2'd0, 1'b1, 32'h101, 32'd0, 6'd7, 32'h00008000);
    check("t3_rreq", 32'(bus_rreq), 32'd1);
    check("t3_ld_wmask", 32'(bus_wmask), 32'd0);
    check("t3_ld_addr", bus_addr, 32'h100);
    step();
    check("t3_pending", 32'(pending), 32'd1);
    ret();
    step();
    issue(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 6'd8, 32'hBEEF0000);
    step();
    ret();
    step();

    // T4: fill the tracker, then retire one to admit a fifth load
    for (int i = 1; i <= 4; i++)
      issue(1'b0, 2'd2, 1'b0, 32'h200 + 32'(4 * i), 32'd0,
            6'(i), 32'h11111111 * i);
    step();
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; req_tag = 6'd5; req_valid = 1'b1;
    #1;
    check("t4_stall", 32'(req_ready), 32'd0);
    check("t4_pending_full", 32'(pending), 32'd4);
    bus_rvalid = 1'b1;
    bus_rdata = rd_q.pop_front();
    #1;
    check("t4_ready_on_rvalid", 32'(req_ready), 32'd1);
    rd_q.push_back(32'h55555555);
    exp_q.push_back('{6'd5, 32'h55555555});
    step();
    bus_rvalid = 1'b0;
    req_valid = 1'b0;
    step();
    check("t4_pending_after", 32'(pending), 32'd4);
    repeat (4) ret();
    step();
    check("t4_drained", 32'(pending), 32'd0);

    // T5: grant and rvalid together, then an unexpected rvalid
    issue(1'b0, 2'd0, 1'b0, 32'h400, 32'd0, 6'd9, 32'h000000F0);
    issue(1'b0, 2'd1, 1'b1, 32'h402, 32'd0, 6'd10, 32'h9ABC0000);
    step();
    check("t5_pending2", 32'(pending), 32'd2);
    bus_gnt = 1'b0;
    issue(1'b0, 2'd0, 1'b1, 32'h403, 32'd0, 6'd11, 32'h7F000000);
    bus_gnt = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata = rd_q.pop_front();
    step();
    bus_rvalid = 1'b0;
    check("t5_pending_same", 32'(pending), 32'd2);
    check("t5_granted", 32'(bus_rreq), 32'd0);
    repeat (2) ret();
    step();
    check("t5_drained", 32'(pending), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    step();
    bus_rvalid = 1'b0;
    check("t5_unexp", 32'(unexp_rvalid), 32'd1);
    check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    step();
    check("t5_pending0", 32'(pending), 32'd0);

    // T6: reset with loads outstanding
    for (int i = 0; i < 3; i++)
      issue(1'b0, 2'd2, 1'b0, 32'h500 + 32'(4 * i), 32'd0,
            6'(20 + i), 32'h0);
    step();
    check("t6_pending3", 32'(pending), 32'd3);
    reset_n = 1'b0;
    step();
    check("t6_rst_pending", 32'(pending), 32'd0);
    check("t6_rst_rreq", 32'(bus_rreq), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    check("t6_rst_rsp", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    rd_q.delete();
    reset_n = 1'b1;
    step();
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    check("t6_unexp", 32'(unexp_rvalid), 32'd1);
    check("t6_pending", 32'(pending), 32'd0);

`ifdef MINIMAX_LSU_MISALIGN_TRAP_EN
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h2; req_tag = 6'd3; req_valid = 1'b1;
    #1;
    check("trap_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("trap_no_rreq", 32'(bus_rreq), 32'd0);
    check("trap_mis_valid", 32'(mis_valid), 32'd1);
    check("trap_mis_addr", mis_addr, 32'h2);
    step();
    check("trap_pulse", 32'(mis_valid), 32'd0);
`endif

    repeat (3) step();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
